udp_perf_rx_checker: RTL and testbench

//  Receive-side traffic checker for the UDP/CMAC loopback perf test; the counterpart of the TX pattern generator.

---
 rtl/udp_perf_pkg.sv | 32 +++
 rtl/udp_perf_pattern_gen.sv | 14 +
 rtl/udp_perf_rx_checker.sv | 252 +++++++++++++++++++++++++
 tb/tb_udp_perf_rx_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/udp_perf_pkg.sv
// Shared definitions for the UDP perf TX generator / RX checker pair:
// lane layout, receive states and length helpers.
package udp_perf_pkg;

  localparam int LANES    = 16;
  localparam int LANE_W   = 32;
  localparam int SEQ_W    = 16;
  localparam int BEAT_W   = 12;
  localparam int LANE_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2
  } rx_state_t;

  // Number of 64-byte beats a packet of 'size' bytes occupies.
  function automatic logic [BEAT_W-1:0] calc_beat_num(input logic [15:0] size);
    return {2'b00, size[15:6]} + {11'd0, (size[5:0] != 6'd0)};
  endfunction

  function automatic logic [63:0] calc_last_keep(input logic [15:0] size);
    logic [63:0] keep;
    if (size[5:0] == 6'd0) begin
      keep = {64{1'b1}};
    end else begin
      keep = (64'd1 << size[5:0]) - 64'd1;
    end
    return keep;
  endfunction

endpackage

// File: rtl/udp_perf_pattern_gen.sv
// Combinational expected-beat generator: lane k = {seq, beat_idx, k}.
module udp_perf_pattern_gen
  import udp_perf_pkg::*;
(
  input  logic [SEQ_W-1:0]        seq,
  input  logic [BEAT_W-1:0]       beat_idx,
  output logic [LANES*LANE_W-1:0] data
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign data[g*LANE_W +: LANE_W] = {seq, beat_idx, LANE_ID_W'(g)};
  end

endmodule

// File: rtl/udp_perf_rx_checker.sv
// Receive-side checker for the UDP/CMAC loopback perf test.
// Define UDP_PERF_RX_PAYLOAD_CHECK_EN to compare every kept byte against the pattern.
module udp_perf_rx_checker
  import udp_perf_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int KEEP_WIDTH     = 64,
  parameter int USER_WIDTH     = 1,
  parameter int CNT_WIDTH      = 32,
  parameter int PKT_SIZE_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      rx_axis_tvalid,
  output logic                      rx_axis_tready,
  input  logic [DATA_WIDTH-1:0]     rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]     rx_axis_tkeep,
  input  logic                      rx_axis_tlast,
  input  logic [USER_WIDTH-1:0]     rx_axis_tuser,
  input  logic                      cfg_enable,
  input  logic                      cfg_clear,
  input  logic [PKT_SIZE_WIDTH-1:0] cfg_pkt_size,
  output logic [CNT_WIDTH-1:0]      recv_pkt_num,
  output logic [CNT_WIDTH-1:0]      err_pkt_num,
  output logic [CNT_WIDTH-1:0]      seq_err_num,
  output logic [CNT_WIDTH-1:0]      total_beat_num,
  output logic [CNT_WIDTH-1:0]      perf_cycle_num,
  output logic [CNT_WIDTH-1:0]      perf_beat_num,
  output logic                      perf_cycle_full,
  output logic                      is_recv_first_pkt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  rx_state_t             state_q, state_d;
  logic                  tready_q, tready_d;
  logic                  in_pkt_q, in_pkt_d;
  logic                  discard_q, discard_d;
  logic                  pkt_err_q, pkt_err_d;
  logic [BEAT_W-1:0]     beat_idx_q, beat_idx_d;
  logic [BEAT_W-1:0]     exp_beats_q, exp_beats_d;
  logic [KEEP_WIDTH-1:0] exp_keep_q, exp_keep_d;
  logic [SEQ_W-1:0]      pkt_seq_q, pkt_seq_d;
  logic [SEQ_W-1:0]      exp_seq_q, exp_seq_d;
  logic                  seq_valid_q, seq_valid_d;
  logic [CNT_WIDTH-1:0]  recv_q, recv_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [CNT_WIDTH-1:0]  seq_err_q, seq_err_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;
  logic [CNT_WIDTH-1:0]  perf_cyc_q, perf_cyc_d;
  logic [CNT_WIDTH-1:0]  perf_beat_q, perf_beat_d;
  logic                  full_q, full_d;
  logic                  first_q, first_d;

  logic                  hs_s;
  logic                  count_beat_s;
  logic                  first_beat_s;
  logic [BEAT_W-1:0]     cur_n_s;
  logic [BEAT_W-1:0]     cur_idx_s;
  logic [KEEP_WIDTH-1:0] cur_keep_s;
  logic [SEQ_W-1:0]      cur_seq_s;
  logic [SEQ_W-1:0]      beat_seq_s;
  logic                  beat_err_s;
  logic                  payload_err_s;
  logic                  pkt_bad_s;
  logic                  boundary_s;

  assign hs_s         = rx_axis_tvalid & tready_q;
  assign count_beat_s = hs_s & ~discard_q;
  assign first_beat_s = ~in_pkt_q;
  assign beat_seq_s   = rx_axis_tdata[LANE_W-1 -: SEQ_W];

  // Length and keep expectations are latched on beat 0 so later size changes cannot disturb a packet.
  assign cur_n_s    = first_beat_s ? calc_beat_num(cfg_pkt_size) : exp_beats_q;
  assign cur_keep_s = first_beat_s ? calc_last_keep(cfg_pkt_size) : exp_keep_q;
  assign cur_idx_s  = first_beat_s ? {BEAT_W{1'b0}} : beat_idx_q;
  assign cur_seq_s  = first_beat_s ? beat_seq_s : pkt_seq_q;

`ifdef UDP_PERF_RX_PAYLOAD_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_beat_s;

  udp_perf_pattern_gen u_pattern_gen (
    .seq      (cur_seq_s),
    .beat_idx (cur_idx_s),
    .data     (exp_beat_s)
  );

  // Byte-wise compare, masked by tkeep.
  always_comb begin
    payload_err_s = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      payload_err_s = payload_err_s |
                      (rx_axis_tkeep[i] & (rx_axis_tdata[i*8 +: 8] != exp_beat_s[i*8 +: 8]));
    end
  end
`else
  logic unused_payload_s;

  assign payload_err_s    = 1'b0;
  assign unused_payload_s = ^{rx_axis_tdata[DATA_WIDTH-1:LANE_W],
                              rx_axis_tdata[LANE_W-SEQ_W-1:0], cur_seq_s};
`endif

  assign beat_err_s =
      ( rx_axis_tlast & ((cur_idx_s != cur_n_s - 12'd1) | (rx_axis_tkeep != cur_keep_s))) |
      (~rx_axis_tlast & ((cur_idx_s >= cur_n_s - 12'd1) | (rx_axis_tkeep != {KEEP_WIDTH{1'b1}}))) |
      rx_axis_tuser[0] | payload_err_s;

  assign pkt_bad_s = (~first_beat_s & pkt_err_q) | beat_err_s;

  // Next-state logic for packet tracking, sequence checking, counters and the receive FSM.
  always_comb begin
    state_d     = state_q;
    in_pkt_d    = hs_s ? ~rx_axis_tlast : in_pkt_q;
    discard_d   = (hs_s & rx_axis_tlast) ? 1'b0 : discard_q;
    pkt_err_d   = pkt_err_q;
    beat_idx_d  = beat_idx_q;
    exp_beats_d = exp_beats_q;
    exp_keep_d  = exp_keep_q;
    pkt_seq_d   = pkt_seq_q;
    exp_seq_d   = exp_seq_q;
    seq_valid_d = seq_valid_q;
    recv_d      = recv_q;
    err_d       = err_q;
    seq_err_d   = seq_err_q;
    total_d     = total_q;
    perf_cyc_d  = perf_cyc_q;
    perf_beat_d = perf_beat_q;
    full_d      = full_q;
    first_d     = first_q;
    boundary_s  = ~in_pkt_d;

    if (cfg_clear) begin
      discard_d   = in_pkt_d;
      pkt_err_d   = 1'b0;
      seq_valid_d = 1'b0;
      recv_d      = '0;
      err_d       = '0;
      seq_err_d   = '0;
      total_d     = '0;
      perf_cyc_d  = '0;
      perf_beat_d = '0;
      full_d      = 1'b0;
      first_d     = 1'b0;
      state_d     = WAIT_FIRST;
    end else begin
      if (count_beat_s) begin
        beat_idx_d  = (cur_idx_s == {BEAT_W{1'b1}}) ? cur_idx_s : cur_idx_s + 12'd1;
        exp_beats_d = cur_n_s;
        exp_keep_d  = cur_keep_s;
        pkt_seq_d   = cur_seq_s;
        pkt_err_d   = pkt_bad_s;
        total_d     = sat_inc(total_q);
        perf_beat_d = full_q ? perf_beat_q : sat_inc(perf_beat_q);
        first_d     = 1'b1;
        if (first_beat_s) begin
          seq_valid_d = 1'b1;
          exp_seq_d   = beat_seq_s + 16'd1;
          seq_err_d   = (seq_valid_q && (beat_seq_s != exp_seq_q)) ? sat_inc(seq_err_q) : seq_err_q;
        end else begin
          seq_err_d   = seq_err_q;
        end
        if (rx_axis_tlast) begin
          recv_d = sat_inc(recv_q);
          err_d  = pkt_bad_s ? sat_inc(err_q) : err_q;
        end else begin
          recv_d = recv_q;
        end
      end else begin
        total_d = total_q;
      end

      perf_cyc_d = (first_d && !full_q) ? sat_inc(perf_cyc_q) : perf_cyc_q;
      full_d     = full_q | (perf_cyc_d == CNT_MAX);

      case (state_q)
        IDLE:       state_d = cfg_enable ? WAIT_FIRST : IDLE;
        WAIT_FIRST: begin
          if (!cfg_enable && boundary_s) begin
            state_d = IDLE;
          end else begin
            state_d = count_beat_s ? RUN : WAIT_FIRST;
          end
        end
        RUN:        state_d = (!cfg_enable && boundary_s) ? IDLE : RUN;
        default:    state_d = IDLE;
      endcase
    end

    tready_d = (state_d != IDLE);
  end

  // State and counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      tready_q    <= 1'b0;
      in_pkt_q    <= 1'b0;
      discard_q   <= 1'b0;
      pkt_err_q   <= 1'b0;
      beat_idx_q  <= '0;
      exp_beats_q <= '0;
      exp_keep_q  <= '0;
      pkt_seq_q   <= '0;
      exp_seq_q   <= '0;
      seq_valid_q <= 1'b0;
      recv_q      <= '0;
      err_q       <= '0;
      seq_err_q   <= '0;
      total_q     <= '0;
      perf_cyc_q  <= '0;
      perf_beat_q <= '0;
      full_q      <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      in_pkt_q    <= in_pkt_d;
      discard_q   <= discard_d;
      pkt_err_q   <= pkt_err_d;
      beat_idx_q  <= beat_idx_d;
      exp_beats_q <= exp_beats_d;
      exp_keep_q  <= exp_keep_d;
      pkt_seq_q   <= pkt_seq_d;
      exp_seq_q   <= exp_seq_d;
      seq_valid_q <= seq_valid_d;
      recv_q      <= recv_d;
      err_q       <= err_d;
      seq_err_q   <= seq_err_d;
      total_q     <= total_d;
      perf_cyc_q  <= perf_cyc_d;
      perf_beat_q <= perf_beat_d;
      full_q      <= full_d;
      first_q     <= first_d;
    end
  end

  assign rx_axis_tready    = tready_q;
  assign recv_pkt_num      = recv_q;
  assign err_pkt_num       = err_q;
  assign seq_err_num       = seq_err_q;
  assign total_beat_num    = total_q;
  assign perf_cycle_num    = perf_cyc_q;
  assign perf_beat_num     = perf_beat_q;
  assign perf_cycle_full   = full_q;
  assign is_recv_first_pkt = first_q;

endmodule

// File: tb/tb_udp_perf_rx_checker.sv
// Directed self-checking bench for udp_perf_rx_checker.
module tb_udp_perf_rx_checker;

  logic         CLK;
  logic         RST_N;
  logic         rx_axis_tvalid;
  logic         rx_axis_tready;
  logic [511:0] rx_axis_tdata;
  logic [63:0]  rx_axis_tkeep;
  logic         rx_axis_tlast;
  logic [0:0]   rx_axis_tuser;
  logic         cfg_enable;
  logic         cfg_clear;
  logic [15:0]  cfg_pkt_size;
  logic [31:0]  recv_pkt_num;
  logic [31:0]  err_pkt_num;
  logic [31:0]  seq_err_num;
  logic [31:0]  total_beat_num;
  logic [31:0]  perf_cycle_num;
  logic [31:0]  perf_beat_num;
  logic         perf_cycle_full;
  logic         is_recv_first_pkt;

  int n_checks;
  int n_fails;

  localparam logic [63:0] KEEP_ALL = {64{1'b1}};

  udp_perf_rx_checker dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .rx_axis_tvalid    (rx_axis_tvalid),
    .rx_axis_tready    (rx_axis_tready),
    .rx_axis_tdata     (rx_axis_tdata),
    .rx_axis_tkeep     (rx_axis_tkeep),
    .rx_axis_tlast     (rx_axis_tlast),
    .rx_axis_tuser     (rx_axis_tuser),
    .cfg_enable        (cfg_enable),
    .cfg_clear         (cfg_clear),
    .cfg_pkt_size      (cfg_pkt_size),
    .recv_pkt_num      (recv_pkt_num),
    .err_pkt_num       (err_pkt_num),
    .seq_err_num       (seq_err_num),
    .total_beat_num    (total_beat_num),
    .perf_cycle_num    (perf_cycle_num),
    .perf_beat_num     (perf_beat_num),
    .perf_cycle_full   (perf_cycle_full),
    .is_recv_first_pkt (is_recv_first_pkt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] make_beat(input logic [15:0] seq, input int b);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) begin
      d[k*32 +: 32] = {seq, 12'(b), 4'(k)};
    end
    return d;
  endfunction

  // Sends nb beats back to back; flip_beat corrupts one byte, clear_beat pulses cfg_clear with that beat.
  task automatic send_pkt(input logic [15:0] seq, input int nb, input logic [63:0] last_keep,
                          input logic tuser, input int flip_beat, input int clear_beat);
    int wait_cnt;
    for (int b = 0; b < nb; b++) begin
      rx_axis_tvalid = 1'b1;
      rx_axis_tdata  = make_beat(seq, b);
      if (b == flip_beat) rx_axis_tdata[7:0] = rx_axis_tdata[7:0] ^ 8'hFF;
      rx_axis_tkeep  = (b == nb - 1) ? last_keep : KEEP_ALL;
      rx_axis_tlast  = (b == nb - 1);
      rx_axis_tuser  = tuser;
      cfg_clear      = (b == clear_beat);
      wait_cnt = 0;
      while (!rx_axis_tready && wait_cnt < 50) begin
        @(negedge CLK);
        wait_cnt++;
      end
      if (!rx_axis_tready) check_eq("tready_timeout", {63'd0, rx_axis_tready}, 64'd1);
      @(negedge CLK);
    end
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    cfg_clear      = 1'b0;
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1;
    @(negedge CLK);
    cfg_clear = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fails        = 0;
    RST_N          = 1'b0;
    rx_axis_tvalid = 1'b0;
    rx_axis_tdata  = '0;
    rx_axis_tkeep  = '0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    cfg_enable     = 1'b0;
    cfg_clear      = 1'b0;
    cfg_pkt_size   = 16'd256;
    repeat (3) @(negedge CLK);

    check_eq("rst_tready", {63'd0, rx_axis_tready}, 64'd0);
    check_eq("rst_recv", {32'd0, recv_pkt_num}, 64'd0);
    check_eq("rst_total", {32'd0, total_beat_num}, 64'd0);
    check_eq("rst_first", {63'd0, is_recv_first_pkt}, 64'd0);
    check_eq("rst_full", {63'd0, perf_cycle_full}, 64'd0);

    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("idle_tready", {63'd0, rx_axis_tready}, 64'd0);
    cfg_enable = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("enable_tready", {63'd0, rx_axis_tready}, 64'd1);

    // T1: 10 clean packets of 256 bytes, 4 beats each
    pulse_clear();
    for (int p = 0; p < 10; p++) send_pkt(16'(p), 4, KEEP_ALL, 1'b0, -1, -1);
    check_eq("t1_recv", {32'd0, recv_pkt_num}, 64'd10);
    check_eq("t1_err", {32'd0, err_pkt_num}, 64'd0);
    check_eq("t1_seq_err", {32'd0, seq_err_num}, 64'd0);
    check_eq("t1_total", {32'd0, total_beat_num}, 64'd40);
    check_eq("t1_perf_beat", {32'd0, perf_beat_num}, 64'd40);
    check_eq("t1_perf_cycle", {32'd0, perf_cycle_num}, 64'd40);
    check_eq("t1_first", {63'd0, is_recv_first_pkt}, 64'd1);

    // T2: 100 bytes = 2 beats, last keep must be 36 bytes
    pulse_clear();
    cfg_pkt_size = 16'd100;
    send_pkt(16'd0, 2, KEEP_ALL, 1'b0, -1, -1);
    check_eq("t2_bad_keep_err", {32'd0, err_pkt_num}, 64'd1);
    send_pkt(16'd1, 2, 64'h0000_000F_FFFF_FFFF, 1'b0, -1, -1);
    check_eq("t2_good_keep_err", {32'd0, err_pkt_num}, 64'd1);
    check_eq("t2_recv", {32'd0, recv_pkt_num}, 64'd2);

    // T3: sequence gap and 16-bit wrap, single-beat packets
    pulse_clear();
    cfg_pkt_size = 16'd64;
    send_pkt(16'd0, 1, KEEP_ALL, 1'b0, -1, -1);
    send_pkt(16'd1, 1, KEEP_ALL, 1'b0, -1, -1);
    send_pkt(16'd3, 1, KEEP_ALL, 1'b0, -1, -1);
    send_pkt(16'd4, 1, KEEP_ALL, 1'b0, -1, -1);
    check_eq("t3_seq_err", {32'd0, seq_err_num}, 64'd1);
    check_eq("t3_err", {32'd0, err_pkt_num}, 64'd0);
    check_eq("t3_recv", {32'd0, recv_pkt_num}, 64'd4);
    pulse_clear();
    send_pkt(16'hFFFF, 1, KEEP_ALL, 1'b0, -1, -1);
    send_pkt(16'h0000, 1, KEEP_ALL, 1'b0, -1, -1);
    check_eq("t3_wrap_seq_err", {32'd0, seq_err_num}, 64'd0);
    check_eq("t3_wrap_recv", {32'd0, recv_pkt_num}, 64'd2);

    // T4: early tlast, late tlast, tuser error at 256 bytes
    pulse_clear();
    cfg_pkt_size = 16'd256;
    send_pkt(16'd0, 3, KEEP_ALL, 1'b0, -1, -1);
    check_eq("t4_short_err", {32'd0, err_pkt_num}, 64'd1);
    send_pkt(16'd1, 6, KEEP_ALL, 1'b0, -1, -1);
    check_eq("t4_long_err", {32'd0, err_pkt_num}, 64'd2);
    check_eq("t4_recv", {32'd0, recv_pkt_num}, 64'd2);
    check_eq("t4_total", {32'd0, total_beat_num}, 64'd9);
    send_pkt(16'd2, 4, KEEP_ALL, 1'b1, -1, -1);
    check_eq("t4_tuser_err", {32'd0, err_pkt_num}, 64'd3);
    check_eq("t4_seq_err", {32'd0, seq_err_num}, 64'd0);

    // T5: one corrupted byte in beat 1
    pulse_clear();
    send_pkt(16'd0, 4, KEEP_ALL, 1'b0, 1, -1);
`ifdef UDP_PERF_RX_PAYLOAD_CHECK_EN
    check_eq("t5_payload_err", {32'd0, err_pkt_num}, 64'd1);
`else
    check_eq("t5_payload_err", {32'd0, err_pkt_num}, 64'd0);
`endif
    check_eq("t5_recv", {32'd0, recv_pkt_num}, 64'd1);

    // T6: clear coincident with tlast drops that packet
    pulse_clear();
    cfg_pkt_size = 16'd128;
    send_pkt(16'd0, 2, KEEP_ALL, 1'b0, -1, 1);
    check_eq("t6_clr_recv", {32'd0, recv_pkt_num}, 64'd0);
    check_eq("t6_clr_total", {32'd0, total_beat_num}, 64'd0);
    check_eq("t6_clr_first", {63'd0, is_recv_first_pkt}, 64'd0);
    check_eq("t6_clr_perf", {32'd0, perf_cycle_num}, 64'd0);

    // Clear mid-packet: remainder discarded, next packet starts fresh
    cfg_pkt_size = 16'd256;
    send_pkt(16'd5, 4, KEEP_ALL, 1'b0, -1, 1);
    check_eq("t6_discard_total", {32'd0, total_beat_num}, 64'd0);
    send_pkt(16'd7, 4, KEEP_ALL, 1'b0, -1, -1);
    check_eq("t6_after_recv", {32'd0, recv_pkt_num}, 64'd1);
    check_eq("t6_after_total", {32'd0, total_beat_num}, 64'd4);
    check_eq("t6_after_err", {32'd0, err_pkt_num}, 64'd0);
    check_eq("t6_after_seq_err", {32'd0, seq_err_num}, 64'd0);
    check_eq("t6_after_perf", {32'd0, perf_cycle_num}, 64'd4);

    // Async reset in the middle of a packet
    rx_axis_tvalid = 1'b1;
    rx_axis_tdata  = make_beat(16'd8, 0);
    rx_axis_tkeep  = KEEP_ALL;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_eq("rst_mid_tready", {63'd0, rx_axis_tready}, 64'd0);
    check_eq("rst_mid_recv", {32'd0, recv_pkt_num}, 64'd0);
    check_eq("rst_mid_total", {32'd0, total_beat_num}, 64'd0);
    check_eq("rst_mid_first", {63'd0, is_recv_first_pkt}, 64'd0);
    check_eq("rst_mid_perf", {32'd0, perf_cycle_num}, 64'd0);
    rx_axis_tvalid = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
